// File: rtl/sort_pkg.sv
// Shared constants and state type for the sort-tree frame loader.
package sort_pkg;
   localparam int N_WORDS = 12;
   localparam int DATA_W  = 12;
   localparam int IDX_W   = $clog2(N_WORDS);

   typedef enum logic [1:0] {FILL, EVAL, HOLD} state_e;
endpackage

// File: rtl/sort_frame_loader_if.sv
// Serial sample input and result output handshakes of the frame loader.
interface sort_frame_loader_if import sort_pkg::*; ();
   logic [DATA_W-1:0] in_data;
   logic              in_valid;
   logic              in_ready;
   logic [DATA_W-1:0] out_data;
   logic              out_valid;
   logic              out_ready;

   modport slave (
      input  in_data, in_valid, out_ready,
      output in_ready, out_data, out_valid
   );
   modport master (
      output in_data, in_valid, out_ready,
      input  in_ready, out_data, out_valid
   );
endinterface

// File: rtl/sort_lane_bank.sv
// N_WORDS x DATA_W register bank with a single indexed write port and a
// flattened read-out feeding the sort tree inputs.
module sort_lane_bank import sort_pkg::*; (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      we,
   input  logic [IDX_W-1:0]          wr_idx,
   input  logic [DATA_W-1:0]         wr_data,
   output logic [N_WORDS*DATA_W-1:0] lane_data
);
   logic [N_WORDS-1:0][DATA_W-1:0] lane_q, lane_d;

   for (genvar k = 0; k < N_WORDS; k++) begin : g_lane
      always_comb begin
         lane_d[k] = lane_q[k];
         if (we && wr_idx == IDX_W'(k)) lane_d[k] = wr_data;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) lane_q <= '0;
      else     lane_q <= lane_d;
   end

   // Packed lane k occupies bits [k*DATA_W +: DATA_W].
   assign lane_data = lane_q;
endmodule

// File: rtl/sort_frame_loader.sv
// Serial-to-parallel front-end for the 12-input sort tree: FILL -> EVAL -> HOLD.
// Optional SORT_LOADER_FLUSH_EN adds a flush input that restarts a partial frame.
module sort_frame_loader import sort_pkg::*; #(
   parameter int CNT_W = 16
) (
   input  logic                      clk,
   input  logic                      rst,
   sort_frame_loader_if.slave        bus,
   output logic [N_WORDS*DATA_W-1:0] lane_data,
   input  logic [DATA_W-1:0]         tree_result,
`ifdef SORT_LOADER_FLUSH_EN
   input  logic                      flush,
`endif
   output logic [CNT_W-1:0]          frame_cnt
);
   state_e             state_q, state_d;
   logic [IDX_W-1:0]   wr_idx_q, wr_idx_d;
   logic [DATA_W-1:0]  out_data_q, out_data_d;
   logic               out_valid_q, out_valid_d;
   logic [CNT_W-1:0]   frame_cnt_q, frame_cnt_d;
   logic               we;
   logic               flush_c;

`ifdef SORT_LOADER_FLUSH_EN
   assign flush_c = flush;
`else
   assign flush_c = 1'b0;
`endif

   always_comb begin
      state_d     = state_q;
      wr_idx_d    = wr_idx_q;
      out_data_d  = out_data_q;
      out_valid_d = out_valid_q;
      frame_cnt_d = frame_cnt_q;
      we          = 1'b0;
      case (state_q)
         FILL: begin
            // Flush wins over any transfer in the same cycle, including the 12th.
            if (flush_c) begin
               wr_idx_d = '0;
            end else if (bus.in_valid) begin
               we = 1'b1;
               if (wr_idx_q == IDX_W'(N_WORDS-1)) begin
                  wr_idx_d = '0;
                  state_d  = EVAL;
               end else begin
                  wr_idx_d = wr_idx_q + 1'b1;
               end
            end
         end
         EVAL: begin
            out_data_d  = tree_result;
            out_valid_d = 1'b1;
            state_d     = HOLD;
         end
         HOLD: begin
            if (bus.out_ready) begin
               out_valid_d = 1'b0;
               frame_cnt_d = frame_cnt_q + 1'b1;
               state_d     = FILL;
            end
         end
         default: state_d = FILL;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= FILL;
         wr_idx_q    <= '0;
         out_data_q  <= '0;
         out_valid_q <= 1'b0;
         frame_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         wr_idx_q    <= wr_idx_d;
         out_data_q  <= out_data_d;
         out_valid_q <= out_valid_d;
         frame_cnt_q <= frame_cnt_d;
      end
   end

   sort_lane_bank u_bank (
      .clk       (clk),
      .rst       (rst),
      .we        (we),
      .wr_idx    (wr_idx_q),
      .wr_data   (bus.in_data),
      .lane_data (lane_data)
   );

   assign bus.in_ready  = (state_q == FILL);
   assign bus.out_data  = out_data_q;
   assign bus.out_valid = out_valid_q;
   assign frame_cnt     = frame_cnt_q;
endmodule

// File: tb/tb_sort_frame_loader.sv
// Scoreboard bench: a frame-level reference model predicts each result; a
// separate monitor pops and compares whenever out_valid is presented.
module tb_sort_frame_loader;
   import sort_pkg::*;

   localparam int CW = 4;
`ifdef SORT_LOADER_FLUSH_EN
   localparam bit FLUSH_EN = 1'b1;
`else
   localparam bit FLUSH_EN = 1'b0;
`endif
   localparam int LW = N_WORDS*DATA_W;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   sort_frame_loader_if bus ();
   logic [LW-1:0]     lane_data;
   logic [DATA_W-1:0] tree_result;
   logic [CW-1:0]     frame_cnt;
`ifdef SORT_LOADER_FLUSH_EN
   logic flush = 1'b0;
`endif

   sort_frame_loader #(.CNT_W(CW)) dut (
      .clk         (clk),
      .rst         (rst),
      .bus         (bus),
      .lane_data   (lane_data),
      .tree_result (tree_result),
`ifdef SORT_LOADER_FLUSH_EN
      .flush       (flush),
`endif
      .frame_cnt   (frame_cnt)
   );

   // Stand-in sort tree: returns the largest lane.
   always_comb begin
      tree_result = '0;
      for (int k = 0; k < N_WORDS; k++)
         if (lane_data[k*DATA_W +: DATA_W] > tree_result) tree_result = lane_data[k*DATA_W +: DATA_W];
   end

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   typedef struct {
      logic [DATA_W-1:0] d;
      logic [LW-1:0]     lanes;
      logic [CW-1:0]     cnt;
   } exp_t;
   exp_t sb_q[$];

   // Reference model: what each lane holds, how many samples of the current
   // frame have been taken, and which phase the frame is in.
   logic [DATA_W-1:0] m_lanes [N_WORDS];
   int                m_cnt, m_phase, m_frames;
   logic [DATA_W-1:0] src_q[$];

   function automatic logic [LW-1:0] model_bank();
      logic [LW-1:0] r;
      for (int k = 0; k < N_WORDS; k++) r[k*DATA_W +: DATA_W] = m_lanes[k];
      return r;
   endfunction

   function automatic logic [DATA_W-1:0] model_max();
      logic [DATA_W-1:0] m = '0;
      for (int k = 0; k < N_WORDS; k++) if (m_lanes[k] > m) m = m_lanes[k];
      return m;
   endfunction

   task automatic model_reset();
      for (int k = 0; k < N_WORDS; k++) m_lanes[k] = '0;
      m_cnt = 0; m_phase = 0; m_frames = 0;
      sb_q.delete();
      src_q.delete();
   endtask

   // One clock of stimulus; inputs change 1 time unit after the rising edge.
   task automatic cyc(input bit v, input bit ordy, input bit fl);
      bus.in_valid  = v;
      bus.in_data   = (src_q.size() > 0) ? src_q[0] : DATA_W'($urandom_range(0, 4095));
      bus.out_ready = ordy;
`ifdef SORT_LOADER_FLUSH_EN
      flush = fl;
`endif
      @(negedge clk);
      chk("in_ready", LW'(bus.in_ready), LW'(m_phase == 0));
      case (m_phase)
         0: begin
            if (FLUSH_EN && fl) m_cnt = 0;
            else if (v) begin
               m_lanes[m_cnt] = bus.in_data;
               if (src_q.size() > 0) void'(src_q.pop_front());
               m_cnt++;
               if (m_cnt == N_WORDS) begin m_cnt = 0; m_phase = 1; end
            end
         end
         1: begin
            sb_q.push_back('{d: model_max(), lanes: model_bank(), cnt: CW'(m_frames + 1)});
            m_phase = 2;
         end
         default: if (ordy) begin m_frames++; m_phase = 0; end
      endcase
      @(posedge clk); #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      model_reset();
      @(negedge clk);
      chk("rst_lanes", lane_data, '0);
      chk("rst_out_data", LW'(bus.out_data), '0);
      chk("rst_out_valid", LW'(bus.out_valid), '0);
      chk("rst_frame_cnt", LW'(frame_cnt), '0);
      chk("rst_in_ready", LW'(bus.in_ready), LW'(1));
      @(posedge clk); #1;
      rst = 1'b0;
   endtask

   task automatic run_frames(input int n, input int vduty, input int rduty, input int fduty);
      int target = m_frames + n;
      for (int c = 0; c < n*200 && m_frames < target; c++)
         cyc($urandom_range(0, 99) < vduty, $urandom_range(0, 99) < rduty,
             FLUSH_EN && ($urandom_range(0, 99) < fduty));
      chk("run_frames_budget", LW'(m_frames >= target), LW'(1));
   endtask

   // Monitor: independent of the driver, compares whatever the DUT presents.
   exp_t cur;
   bit   have = 1'b0;
   bit   cnt_chk = 1'b0;
   logic [CW-1:0] cnt_exp;
   int   age = 0;

   always @(negedge clk) begin
      if (rst) begin
         have = 1'b0; cnt_chk = 1'b0; age = 0;
      end else begin
         if (cnt_chk) begin
            chk("frame_cnt", LW'(frame_cnt), LW'(cnt_exp));
            cnt_chk = 1'b0;
         end
         if (bus.out_valid) begin
            age = 0;
            if (!have) begin
               if (sb_q.size() == 0) chk("spurious_out_valid", LW'(1), LW'(0));
               else begin cur = sb_q.pop_front(); have = 1'b1; end
            end
            if (have) begin
               chk("out_data", LW'(bus.out_data), LW'(cur.d));
               chk("lane_data_hold", lane_data, cur.lanes);
               chk("in_ready_hold", LW'(bus.in_ready), LW'(0));
               if (bus.out_ready) begin
                  cnt_chk = 1'b1; cnt_exp = cur.cnt; have = 1'b0;
               end
            end
         end else if (sb_q.size() > 0 && !have) begin
            age++;
            if (age >= 3) begin
               chk("out_valid_latency", LW'(0), LW'(1));
               void'(sb_q.pop_front());
               age = 0;
            end
         end
      end
   end

   initial begin
      logic [DATA_W-1:0] dir [N_WORDS] = '{5, 17, 3, 900, 42, 7, 0, 11, 256, 4095, 1, 8};
      bus.in_valid = 1'b0; bus.in_data = '0; bus.out_ready = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;

      // Directed frame, downstream always ready.
      do_reset();
      foreach (dir[k]) src_q.push_back(dir[k]);
      run_frames(1, 100, 100, 0);
      chk("dir_frame_cnt", LW'(frame_cnt), LW'(1));

      // Same frame with downstream stalled for 10 cycles while in_valid keeps pulsing.
      do_reset();
      foreach (dir[k]) src_q.push_back(dir[k]);
      for (int c = 0; c < 40 && m_phase != 2; c++) cyc(1'b1, 1'b0, 1'b0);
      repeat (10) cyc($urandom_range(0, 1) == 1, 1'b0, 1'b0);
      cyc(1'b0, 1'b1, 1'b0);
      cyc(1'b0, 1'b0, 1'b0);
      chk("stall_frame_cnt", LW'(frame_cnt), LW'(1));

      // Random gaps over three frames.
      do_reset();
      run_frames(3, 50, 50, 0);

      // Reset mid-frame, then a clean frame of 100..111.
      do_reset();
      repeat (6) cyc(1'b1, 1'b1, 1'b0);
      do_reset();
      for (int k = 0; k < N_WORDS; k++) src_q.push_back(DATA_W'(100 + k));
      run_frames(1, 100, 100, 0);
      cyc(1'b0, 1'b0, 1'b0);
      chk("restart_frame_cnt", LW'(frame_cnt), LW'(1));

      // Enough frames to wrap the narrowed counter.
      run_frames(18, 70, 80, 0);

`ifdef SORT_LOADER_FLUSH_EN
      do_reset();
      repeat (7) cyc(1'b1, 1'b1, 1'b0);
      cyc(1'b1, 1'b1, 1'b1);
      for (int k = 0; k < N_WORDS; k++) src_q.push_back(DATA_W'(20));
      run_frames(1, 100, 100, 0);
      repeat (11) cyc(1'b1, 1'b1, 1'b0);
      cyc(1'b1, 1'b1, 1'b1);
      cyc(1'b0, 1'b1, 1'b0);
      run_frames(1, 100, 100, 0);
      run_frames(5, 60, 60, 10);
`endif

      repeat (4) cyc(1'b0, 1'b1, 1'b0);
      chk("sb_drain", LW'(sb_q.size() + int'(have)), LW'(0));
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
